// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: instruction ids, commit classes and FSM states shared by commit and issue logic
package commit_unit_pkg;
  localparam int ID_W = 6;
  localparam logic [ID_W-1:0] ID_LUI   = 6'd1;
  localparam logic [ID_W-1:0] ID_AUIPC = 6'd2;
  localparam logic [ID_W-1:0] ID_JAL   = 6'd3;
  localparam logic [ID_W-1:0] ID_JALR  = 6'd4;
  localparam logic [ID_W-1:0] ID_BEQ   = 6'd5;
  localparam logic [ID_W-1:0] ID_BNE   = 6'd6;
  localparam logic [ID_W-1:0] ID_BLT   = 6'd7;
  localparam logic [ID_W-1:0] ID_BGE   = 6'd8;
  localparam logic [ID_W-1:0] ID_BLTU  = 6'd9;
  localparam logic [ID_W-1:0] ID_BGEU  = 6'd10;
  localparam logic [ID_W-1:0] ID_LB    = 6'd11;
  localparam logic [ID_W-1:0] ID_LH    = 6'd12;
  localparam logic [ID_W-1:0] ID_LW    = 6'd13;
  localparam logic [ID_W-1:0] ID_LBU   = 6'd14;
  localparam logic [ID_W-1:0] ID_LHU   = 6'd15;
  localparam logic [ID_W-1:0] ID_SB    = 6'd16;
  localparam logic [ID_W-1:0] ID_SH    = 6'd17;
  localparam logic [ID_W-1:0] ID_SW    = 6'd18;
  localparam logic [ID_W-1:0] ID_ADDI  = 6'd19;
  localparam logic [ID_W-1:0] ID_ADD   = 6'd28;
  typedef enum logic [1:0] {CLS_OTHER = 2'd0, CLS_STORE = 2'd1, CLS_BRANCH = 2'd2} cls_e;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;
endpackage

// File: rtl/commit_classify.sv
// commit_classify: combinational instruction-id to commit-class decoder (store / branch / other)
module commit_classify
  import commit_unit_pkg::*;
(
  input  logic [ID_W-1:0] instr_id_i,
  output cls_e            cls_o
);
  always_comb
    cls_o = (instr_id_i inside {ID_SB, ID_SH, ID_SW}) ? CLS_STORE :
            (instr_id_i >= ID_BEQ && instr_id_i <= ID_BGEU) ? CLS_BRANCH : CLS_OTHER;
endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement with regfile writeback, store release and mispredict flush.
// COMMIT_PERF_EN adds retired/flush event counters.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_IDX_W    = 4,
  parameter int LSB_IDX_W    = 4,
  parameter int REG_IDX_W    = 5,
  parameter int INSTR_ID_W   = 6,
  parameter int WORD_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  rob_commit_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [REG_IDX_W-1:0]  rd_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic [LSB_IDX_W-1:0]  lsb_pos_in,
  input  logic [WORD_W-1:0]     res_in,
  input  logic                  jump_en_in,
  input  logic [ADDR_W-1:0]     jump_a_in,
  output logic                  rf_we_out,
  output logic [REG_IDX_W-1:0]  rf_rd_out,
  output logic [WORD_W-1:0]     rf_data_out,
  output logic [ROB_IDX_W-1:0]  rf_rob_pos_out,
  output logic                  st_commit_en_out,
  output logic [LSB_IDX_W-1:0]  st_lsb_pos_out,
  output logic                  pc_redirect_en_out,
  output logic [ADDR_W-1:0]     pc_redirect_a_out,
`ifdef COMMIT_PERF_EN
  output logic [31:0]           retired_cnt_out,
  output logic [31:0]           flush_cnt_out,
`endif
  output logic                  clear_branch_out
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  state_e state_q, state_d;
  cls_e cls;
  logic acc, go;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d, st_q, st_d, redir_q, redir_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ROB_IDX_W-1:0] rob_q, rob_d;
  logic [LSB_IDX_W-1:0] lsb_q, lsb_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  commit_classify u_cls (.instr_id_i(instr_id_in), .cls_o(cls));
  // clear_branch is simply the registered FLUSH state, so it drops the cycle the FSM returns to RUN
  always_comb begin
    acc = rob_commit_en_in && state_q == RUN;
    go = acc && jump_en_in;
    state_d = state_q == FLUSH ? (cnt_q == '0 ? RUN : FLUSH) : (go ? FLUSH : RUN);
    cnt_d = state_q == FLUSH ? (cnt_q == '0 ? '0 : cnt_q - CNT_W'(1)) : (go ? CNT_INIT : cnt_q);
    we_d = acc && cls == CLS_OTHER && rd_in != '0;
    rd_d = we_d ? rd_in : rd_q;
    data_d = we_d ? res_in : data_q;
    rob_d = we_d ? rob_pos_in : rob_q;
    st_d = acc && cls == CLS_STORE;
    lsb_d = st_d ? lsb_pos_in : lsb_q;
    redir_d = go;
    ra_d = go ? jump_a_in : ra_q;
  end
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      state_q <= RUN;
      cnt_q <= '0;
      we_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      rob_q <= '0;
      st_q <= 1'b0;
      lsb_q <= '0;
      redir_q <= 1'b0;
      ra_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      rd_q <= rd_d;
      data_q <= data_d;
      rob_q <= rob_d;
      st_q <= st_d;
      lsb_q <= lsb_d;
      redir_q <= redir_d;
      ra_q <= ra_d;
    end
`ifdef COMMIT_PERF_EN
  logic [31:0] ret_q, fl_q;
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      ret_q <= '0;
      fl_q <= '0;
    end else if (rdy_in) begin
      ret_q <= ret_q + {31'd0, acc};
      fl_q <= fl_q + {31'd0, go};
    end
  assign retired_cnt_out = ret_q;
  assign flush_cnt_out = fl_q;
`endif
  assign rf_we_out = we_q;
  assign rf_rd_out = rd_q;
  assign rf_data_out = data_q;
  assign rf_rob_pos_out = rob_q;
  assign st_commit_en_out = st_q;
  assign st_lsb_pos_out = lsb_q;
  assign pc_redirect_en_out = redir_q;
  assign pc_redirect_a_out = ra_q;
  assign clear_branch_out = state_q == FLUSH;
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed scoreboard bench; main DUT uses FLUSH_CYCLES=3, a second copy uses 1.
module tb_commit_unit;
  import commit_unit_pkg::*;
  typedef struct packed {
    logic en; logic [5:0] id; logic [4:0] rd; logic [3:0] rob; logic [3:0] lsb;
    logic [31:0] res; logic jen; logic [31:0] ja;
  } pkt_t;
  typedef struct packed {
    logic we; logic [4:0] rd; logic [31:0] data; logic [3:0] robp; logic st; logic [3:0] lsbp;
    logic redir; logic [31:0] ra; logic clr; logic clr1;
  } exp_t;
  localparam pkt_t IDLE = '0;
  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  pkt_t cur = '0;
  logic we, st, redir, clr, we1, st1, redir1, clr1;
  logic [4:0] rd, rd1;
  logic [31:0] data, ra, data1, ra1;
  logic [3:0] robp, lsbp, robp1, lsbp1;
`ifdef COMMIT_PERF_EN
  logic [31:0] ret, fl, ret1, fl1;
`endif
  int compared = 0, mismatched = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  commit_unit #(.FLUSH_CYCLES(3)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .rob_commit_en_in(cur.en), .instr_id_in(cur.id),
    .rd_in(cur.rd), .rob_pos_in(cur.rob), .lsb_pos_in(cur.lsb), .res_in(cur.res), .jump_en_in(cur.jen),
    .jump_a_in(cur.ja), .rf_we_out(we), .rf_rd_out(rd), .rf_data_out(data), .rf_rob_pos_out(robp),
    .st_commit_en_out(st), .st_lsb_pos_out(lsbp), .pc_redirect_en_out(redir), .pc_redirect_a_out(ra),
`ifdef COMMIT_PERF_EN
    .retired_cnt_out(ret), .flush_cnt_out(fl),
`endif
    .clear_branch_out(clr));
  commit_unit #(.FLUSH_CYCLES(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .rob_commit_en_in(cur.en), .instr_id_in(cur.id),
    .rd_in(cur.rd), .rob_pos_in(cur.rob), .lsb_pos_in(cur.lsb), .res_in(cur.res), .jump_en_in(cur.jen),
    .jump_a_in(cur.ja), .rf_we_out(we1), .rf_rd_out(rd1), .rf_data_out(data1), .rf_rob_pos_out(robp1),
    .st_commit_en_out(st1), .st_lsb_pos_out(lsbp1), .pc_redirect_en_out(redir1), .pc_redirect_a_out(ra1),
`ifdef COMMIT_PERF_EN
    .retired_cnt_out(ret1), .flush_cnt_out(fl1),
`endif
    .clear_branch_out(clr1));
  function automatic pkt_t pk(logic [5:0] id, logic [4:0] r, logic [3:0] rob, logic [3:0] lsb,
                              logic [31:0] res, logic jen, logic [31:0] ja);
    pk = '{1'b1, id, r, rob, lsb, res, jen, ja};
  endfunction
  function automatic exp_t ex(logic w, logic [4:0] r, logic [31:0] d, logic [3:0] rb, logic s,
                              logic [3:0] l, logic rr, logic [31:0] a, logic c, logic c1);
    ex = '{w, r, d, rb, s, l, rr, a, c, c1};
  endfunction
  function automatic exp_t ez(logic c, logic c1);
    ez = ex(0, 0, 0, 0, 0, 0, 0, 0, c, c1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic step(input pkt_t p, input logic r, input logic rn, input exp_t e);
    exp_t g;
    @(negedge clk);
    cur = p; rdy = r; rst_n = rn;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("rf_we", 32'(we), 32'(g.we));
    if (g.we) begin
      chk("rf_rd", 32'(rd), 32'(g.rd));
      chk("rf_data", data, g.data);
      chk("rf_rob_pos", 32'(robp), 32'(g.robp));
    end
    chk("st_en", 32'(st), 32'(g.st));
    if (g.st) chk("st_lsb_pos", 32'(lsbp), 32'(g.lsbp));
    chk("redir_en", 32'(redir), 32'(g.redir));
    if (g.redir) chk("redir_a", ra, g.ra);
    chk("clear", 32'(clr), 32'(g.clr));
    chk("clear_fc1", 32'(clr1), 32'(g.clr1));
  endtask
  initial begin
    step(IDLE, 1, 0, ez(0, 0));
    step(IDLE, 0, 0, ez(0, 0));
    chk("rst_rd", 32'(rd), 0);
    chk("rst_data", data, 0);
    chk("rst_redir_a", ra, 0);
    step(IDLE, 1, 1, ez(0, 0));
    // single writeback pulse
    step(pk(ID_ADD, 5, 3, 0, 32'h1234, 0, 0), 1, 1, ex(1, 5, 32'h1234, 3, 0, 0, 0, 0, 0, 0));
    step(IDLE, 1, 1, ez(0, 0));
    // store release, then x0 destination never writes
    step(pk(ID_SW, 9, 1, 7, 32'hdead, 0, 0), 1, 1, ex(0, 0, 0, 0, 1, 7, 0, 0, 0, 0));
    step(pk(ID_ADDI, 0, 2, 0, 32'h55, 0, 0), 1, 1, ez(0, 0));
    step(IDLE, 1, 1, ez(0, 0));
    // mispredicted branch; commit during flush is dropped
    step(pk(ID_BEQ, 4, 5, 0, 32'h9, 1, 32'h1000), 1, 1, ex(0, 0, 0, 0, 0, 0, 1, 32'h1000, 1, 1));
    step(pk(ID_ADD, 6, 6, 0, 32'h66, 0, 0), 1, 1, ez(1, 0));
    step(IDLE, 1, 1, ez(1, 0));
    step(IDLE, 1, 1, ez(0, 0));
    // jalr: writeback and redirect in the same cycle
    step(pk(ID_JALR, 1, 2, 0, 32'h44, 1, 32'h80), 1, 1, ex(1, 1, 32'h44, 2, 0, 0, 1, 32'h80, 1, 1));
    step(IDLE, 1, 1, ez(1, 0));
    step(IDLE, 1, 1, ez(1, 0));
    step(IDLE, 1, 1, ez(0, 0));
    // back-to-back with a two-cycle stall holding the pulse
    step(pk(ID_ADD, 7, 4, 0, 32'ha, 0, 0), 1, 1, ex(1, 7, 32'ha, 4, 0, 0, 0, 0, 0, 0));
    step(pk(ID_ADD, 8, 5, 0, 32'hb, 0, 0), 0, 1, ex(1, 7, 32'ha, 4, 0, 0, 0, 0, 0, 0));
    step(pk(ID_ADD, 8, 5, 0, 32'hb, 0, 0), 0, 1, ex(1, 7, 32'ha, 4, 0, 0, 0, 0, 0, 0));
    step(pk(ID_ADD, 8, 5, 0, 32'hb, 0, 0), 1, 1, ex(1, 8, 32'hb, 5, 0, 0, 0, 0, 0, 0));
    step(pk(ID_SH, 3, 6, 3, 32'h0, 0, 0), 1, 1, ex(0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    step(IDLE, 1, 1, ez(0, 0));
    // reset during flush, with rdy low, still clears
    step(pk(ID_BNE, 2, 7, 0, 32'h0, 1, 32'h200), 1, 1, ex(0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 1));
    step(IDLE, 0, 0, ez(0, 0));
    step(IDLE, 1, 1, ez(0, 0));
    // ten commits with two mispredicts
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) begin
        step(pk(ID_BGE, 0, 4'(i), 0, 0, 1, 32'(i * 16)), 1, 1, ex(0, 0, 0, 0, 0, 0, 1, 32'(i * 16), 1, 1));
        step(IDLE, 1, 1, ez(1, 0));
        step(IDLE, 1, 1, ez(1, 0));
        step(IDLE, 1, 1, ez(0, 0));
      end else
        step(pk(ID_ADD, 5'(i + 1), 4'(i), 0, 32'(i * 3), 0, 0), 1, 1,
             ex(1, 5'(i + 1), 32'(i * 3), 4'(i), 0, 0, 0, 0, 0, 0));
    end
    step(IDLE, 1, 1, ez(0, 0));
`ifdef COMMIT_PERF_EN
    chk("retired_cnt", ret, 10);
    chk("flush_cnt", fl, 2);
    chk("retired_cnt_fc1", ret1, 10);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
